// File: rtl/hazard_unit.sv
// hazard_unit: forwarding selects, stage stall/flush generation, a
// multi-cycle E-stage sequencer (freezes F/D/E, bubbles M while the op
// runs) and a saturating count of fetch-stall cycles.
//
// The stall and flush outputs are produced independently. Each stage
// register gives its flush priority over its stall, so a stage may see
// both asserted in the same cycle.
module hazard_unit #(
    parameter int MC_LATENCY  = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             RA1D,
    input  logic [3:0]             RA2D,
    input  logic [3:0]             RA1E,
    input  logic [3:0]             RA2E,
    input  logic [3:0]             WA3E,
    input  logic [3:0]             WA3M,
    input  logic [3:0]             WA3W,
    input  logic                   RegWriteM,
    input  logic                   RegWriteW,
    input  logic                   MemtoRegE,
    input  logic                   PCWrPendingF,
    input  logic                   PCSrcW,
    input  logic                   BranchTakenE,
    input  logic                   MultiCycleE,
    input  logic                   ClearCount,
    output logic [1:0]             ForwardAE,
    output logic [1:0]             ForwardBE,
    output logic                   StallF,
    output logic                   StallD,
    output logic                   StallE,
    output logic                   FlushD,
    output logic                   FlushE,
    output logic                   FlushM,
    output logic                   McBusy,
    output logic [COUNT_WIDTH-1:0] StallCycles
);

    localparam int CW = $clog2(MC_LATENCY);
    // The first stall cycle is spent in IDLE, the last BUSY cycle releases,
    // so BUSY counts down from MC_LATENCY-2 to 0.
    localparam logic [CW-1:0] CNT_LOAD = CW'(MC_LATENCY - 2);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt, cnt_next;
    logic          mc_stall;
    logic          ld_stall;

    // Forwarding select: the younger result in M wins over W; r15 is the PC
    // and is never forwarded.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && (WA3M == RA1E) && (RA1E != 4'hF))
            ForwardAE = 2'b10;
        else if (RegWriteW && (WA3W == RA1E) && (RA1E != 4'hF))
            ForwardAE = 2'b01;
        if (RegWriteM && (WA3M == RA2E) && (RA2E != 4'hF))
            ForwardBE = 2'b10;
        else if (RegWriteW && (WA3W == RA2E) && (RA2E != 4'hF))
            ForwardBE = 2'b01;
    end

    // Load-use: the instruction in D needs a value the load in E has not fetched yet.
    assign ld_stall = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));

    // Sequencer state register and countdown.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // Sequencer next state; a PC write from W aborts a wrong-path op at once.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        mc_stall   = 1'b0;
        if (PCSrcW) begin
            next_state = IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MultiCycleE) begin
                        mc_stall   = 1'b1;
                        next_state = BUSY;
                        cnt_next   = CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        mc_stall = 1'b1;
                        cnt_next = cnt - 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Stage control outputs.
    always_comb begin
        McBusy = (state == BUSY);
        StallF = ld_stall | PCWrPendingF | mc_stall;
        StallD = ld_stall | mc_stall;
        StallE = mc_stall;
        FlushD = PCWrPendingF | PCSrcW | BranchTakenE;
        FlushE = (ld_stall & ~mc_stall) | BranchTakenE | PCSrcW;
        FlushM = mc_stall;
    end

    // Fetch-stall counter: clear wins, otherwise count up and stick at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            StallCycles <= '0;
        else if (ClearCount)
            StallCycles <= '0;
        else if (StallF && (StallCycles != {COUNT_WIDTH{1'b1}}))
            StallCycles <= StallCycles + 1'b1;
    end

endmodule
